text_page_render: RTL and testbench

- Parametrised multi-line text overlay renderer for static VGA pages (start, game-over, pause).
- For each scanned pixel it tests N_LINES text boxes and fetches the glyph row from an external font ROM. It then emits an RGB565 pixel with a fixed 3-cycle latency.
- Per line it adds position, integer scaling, colour and optional blinking (e.g. "PRESS ANY KEY").
- Sits between the VGA timing generator and the page mux.

---
 rtl/text_pkg.sv | 33 +++
 rtl/text_line_hit.sv | 68 ++++++
 rtl/text_page_render.sv | 184 ++++++++++++++++++
 tb/tb_text_page_render.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared constants for the text overlay renderer: character codes,
// RGB565 colours, default glyph geometry and VGA screen size.
package text_pkg;

    localparam int CODE_W      = 5;
    localparam int GLYPH_W_DEF = 8;
    localparam int GLYPH_H_DEF = 16;
    localparam int VGA_WIDTH   = 640;
    localparam int VGA_HEIGHT  = 480;

    localparam logic [4:0] CH_A = 5'd0,  CH_B = 5'd1,  CH_C = 5'd2,  CH_D = 5'd3;
    localparam logic [4:0] CH_E = 5'd4,  CH_F = 5'd5,  CH_G = 5'd6,  CH_H = 5'd7;
    localparam logic [4:0] CH_I = 5'd8,  CH_J = 5'd9,  CH_K = 5'd10, CH_L = 5'd11;
    localparam logic [4:0] CH_M = 5'd12, CH_N = 5'd13, CH_O = 5'd14, CH_P = 5'd15;
    localparam logic [4:0] CH_Q = 5'd16, CH_R = 5'd17, CH_S = 5'd18, CH_T = 5'd19;
    localparam logic [4:0] CH_U = 5'd20, CH_V = 5'd21, CH_W = 5'd22, CH_X = 5'd23;
    localparam logic [4:0] CH_Y = 5'd24, CH_Z = 5'd25, CH_SPACE = 5'd26;

    localparam logic [15:0] BLACK       = 16'h0000;
    localparam logic [15:0] WHITE       = 16'hFFFF;
    localparam logic [15:0] SNAKE_GREEN = 16'h5746;

    typedef enum logic {
        PHASE_VISIBLE = 1'b0,
        PHASE_HIDDEN  = 1'b1
    } blink_phase_e;

    // Codes at or above CH_SPACE carry no glyph and render as background.
    function automatic logic is_glyph(input logic [4:0] code);
        return (code < CH_SPACE);
    endfunction

endpackage

// File: rtl/text_line_hit.sv
// Stage-1 hit test for one text line: box containment after scaling,
// blink masking, and extraction of the character code, glyph row and column.
module text_line_hit
    import text_pkg::*;
#(
    parameter int MAX_CHARS = 16,
    parameter int GLYPH_W   = 8,
    parameter int GLYPH_H   = 16,
    parameter int COORD_W   = 10
) (
    input  logic [COORD_W-1:0]         pix_x_i,
    input  logic [COORD_W-1:0]         pix_y_i,
    input  logic                       pix_valid_i,
    input  logic [COORD_W-1:0]         line_x_i,
    input  logic [COORD_W-1:0]         line_y_i,
    input  logic [MAX_CHARS*5-1:0]     line_text_i,
    input  logic [4:0]                 line_len_i,
    input  logic [1:0]                 line_scale_i,
    input  logic                       line_blink_i,
    input  logic                       phase_hidden_i,
    output logic                       hit_o,
    output logic [4:0]                 code_o,
    output logic [$clog2(GLYPH_H)-1:0] row_o,
    output logic [$clog2(GLYPH_W)-1:0] col_o
);

    localparam int GCOL_W = $clog2(GLYPH_W);
    localparam int SPAN_W = COORD_W + 5 + GCOL_W;

    logic [COORD_W-1:0] dx_s;
    logic [COORD_W-1:0] dy_s;
    logic [COORD_W-1:0] sx_s;
    logic [COORD_W-1:0] sy_s;
    logic [COORD_W-1:0] char_idx_s;
    logic [4:0]         len_c_s;
    logic [SPAN_W-1:0]  span_s;
    logic               in_x_s;
    logic               in_y_s;

    // Box-relative offsets; the explicit >= tests keep underflowed offsets from aliasing into the box.
    always_comb begin
        dx_s       = pix_x_i - line_x_i;
        dy_s       = pix_y_i - line_y_i;
        sx_s       = dx_s >> line_scale_i;
        sy_s       = dy_s >> line_scale_i;
        char_idx_s = sx_s >> GCOL_W;
        len_c_s    = (line_len_i > 5'(MAX_CHARS)) ? 5'(MAX_CHARS) : line_len_i;
        span_s     = SPAN_W'(len_c_s) << GCOL_W;
        in_x_s     = (pix_x_i >= line_x_i) && (SPAN_W'(sx_s) < span_s);
        in_y_s     = (pix_y_i >= line_y_i) && (sy_s < COORD_W'(GLYPH_H));
        hit_o      = pix_valid_i && in_x_s && in_y_s && !(line_blink_i && phase_hidden_i);
        row_o      = sy_s[$clog2(GLYPH_H)-1:0];
        col_o      = sx_s[GCOL_W-1:0];
    end

    // Character code under the pixel; indices past the text fall back to code 0 and never hit.
    always_comb begin
        code_o = 5'd0;
        for (int k = 0; k < MAX_CHARS; k++) begin
            if (char_idx_s == COORD_W'(k)) begin
                code_o = line_text_i[k*5 +: 5];
            end else begin
                code_o = code_o;
            end
        end
    end

endmodule

// File: rtl/text_page_render.sv
// Multi-line text overlay renderer: per-line hit test, priority select,
// font ROM fetch and RGB565 pixel output with a fixed 3-cycle latency.
module text_page_render
    import text_pkg::*;
#(
    parameter int N_LINES      = 2,
    parameter int MAX_CHARS    = 16,
    parameter int GLYPH_W      = 8,
    parameter int GLYPH_H      = 16,
    parameter int BLINK_FRAMES = 30,
    parameter int COORD_W      = 10
) (
    input  logic                            vga_clk,
    input  logic                            sys_rst_n,
    input  logic [COORD_W-1:0]              pix_x,
    input  logic [COORD_W-1:0]              pix_y,
    input  logic                            pix_valid,
    input  logic                            frame_start,
    input  logic [N_LINES*MAX_CHARS*5-1:0]  line_text,
    input  logic [N_LINES*5-1:0]            line_len,
    input  logic [N_LINES*COORD_W-1:0]      line_x,
    input  logic [N_LINES*COORD_W-1:0]      line_y,
    input  logic [N_LINES*2-1:0]            line_scale,
    input  logic [N_LINES*16-1:0]           line_fg,
    input  logic [N_LINES-1:0]              line_blink,
    input  logic [15:0]                     bg_color,
    output logic [5+$clog2(GLYPH_H)-1:0]    font_addr,
    input  logic [GLYPH_W-1:0]              font_data,
    output logic [15:0]                     pix_data,
    output logic                            pix_data_valid
);

    localparam int GROW_W = $clog2(GLYPH_H);
    localparam int GCOL_W = $clog2(GLYPH_W);
    localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Blink state
    logic [BCNT_W-1:0] blink_cnt_q, blink_cnt_d;
    blink_phase_e      phase_q, phase_d;

    // Per-line stage-1 results
    logic [N_LINES-1:0] hit_s;
    logic [4:0]         code_s [N_LINES];
    logic [GROW_W-1:0]  row_s  [N_LINES];
    logic [GCOL_W-1:0]  col_s  [N_LINES];

    // Priority-selected candidate
    logic               sel_hit_s;
    logic [4:0]         sel_code_s;
    logic [GROW_W-1:0]  sel_row_s;
    logic [GCOL_W-1:0]  sel_col_s;
    logic [15:0]        sel_fg_s;

    // Stage 1 (font_addr is the stage-1 address register)
    logic [5+GROW_W-1:0] font_addr_q;
    logic [GCOL_W-1:0]   s1_col_q;
    logic [15:0]         s1_fg_q;
    logic                s1_hit_q;
    logic                s1_valid_q;

    // Stage 2 (aligned with font_data)
    logic [GCOL_W-1:0]   s2_col_q;
    logic [15:0]         s2_fg_q;
    logic                s2_hit_q;
    logic [4:0]          s2_code_q;
    logic                s2_valid_q;

    // Stage 3 (outputs)
    logic [15:0]         pix_data_q, pix_data_d;
    logic                pix_data_valid_q;
    logic                pix_bit_s;

    for (genvar g = 0; g < N_LINES; g++) begin : g_line
        text_line_hit #(
            .MAX_CHARS (MAX_CHARS),
            .GLYPH_W   (GLYPH_W),
            .GLYPH_H   (GLYPH_H),
            .COORD_W   (COORD_W)
        ) u_hit (
            .pix_x_i        (pix_x),
            .pix_y_i        (pix_y),
            .pix_valid_i    (pix_valid),
            .line_x_i       (line_x[g*COORD_W +: COORD_W]),
            .line_y_i       (line_y[g*COORD_W +: COORD_W]),
            .line_text_i    (line_text[g*MAX_CHARS*5 +: MAX_CHARS*5]),
            .line_len_i     (line_len[g*5 +: 5]),
            .line_scale_i   (line_scale[g*2 +: 2]),
            .line_blink_i   (line_blink[g]),
            .phase_hidden_i (phase_q == PHASE_HIDDEN),
            .hit_o          (hit_s[g]),
            .code_o         (code_s[g]),
            .row_o          (row_s[g]),
            .col_o          (col_s[g])
        );
    end

    // Blink counter: wraps after BLINK_FRAMES frame starts and flips the phase.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (frame_start) begin
            if (blink_cnt_q == BCNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                phase_d     = (phase_q == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
        end
    end

    // Priority select: scan from the highest index down so the lowest hitting index wins.
    always_comb begin
        sel_hit_s  = 1'b0;
        sel_code_s = 5'd0;
        sel_row_s  = '0;
        sel_col_s  = '0;
        sel_fg_s   = 16'h0000;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (hit_s[i]) begin
                sel_hit_s  = 1'b1;
                sel_code_s = code_s[i];
                sel_row_s  = row_s[i];
                sel_col_s  = col_s[i];
                sel_fg_s   = line_fg[i*16 +: 16];
            end else begin
                sel_hit_s  = sel_hit_s;
            end
        end
    end

    // Final pixel colour from the fetched glyph row.
    always_comb begin
        pix_bit_s = font_data[GCOL_W'(GLYPH_W - 1) - s2_col_q];
        if (s2_hit_q && is_glyph(s2_code_q) && pix_bit_s) begin
            pix_data_d = s2_fg_q;
        end else if (s2_valid_q) begin
            pix_data_d = bg_color;
        end else begin
            pix_data_d = BLACK;
        end
    end

    // Pipeline and blink state registers.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            blink_cnt_q      <= '0;
            phase_q          <= PHASE_VISIBLE;
            font_addr_q      <= '0;
            s1_col_q         <= '0;
            s1_fg_q          <= 16'h0000;
            s1_hit_q         <= 1'b0;
            s1_valid_q       <= 1'b0;
            s2_col_q         <= '0;
            s2_fg_q          <= 16'h0000;
            s2_hit_q         <= 1'b0;
            s2_code_q        <= 5'd0;
            s2_valid_q       <= 1'b0;
            pix_data_q       <= 16'h0000;
            pix_data_valid_q <= 1'b0;
        end else begin
            blink_cnt_q      <= blink_cnt_d;
            phase_q          <= phase_d;
            font_addr_q      <= {sel_code_s, sel_row_s};
            s1_col_q         <= sel_col_s;
            s1_fg_q          <= sel_fg_s;
            s1_hit_q         <= sel_hit_s;
            s1_valid_q       <= pix_valid;
            s2_col_q         <= s1_col_q;
            s2_fg_q          <= s1_fg_q;
            s2_hit_q         <= s1_hit_q;
            s2_code_q        <= font_addr_q[5+GROW_W-1:GROW_W];
            s2_valid_q       <= s1_valid_q;
            pix_data_q       <= pix_data_d;
            pix_data_valid_q <= s2_valid_q;
        end
    end

    assign font_addr      = font_addr_q;
    assign pix_data       = pix_data_q;
    assign pix_data_valid = pix_data_valid_q;

endmodule

// File: tb/tb_text_page_render.sv
// Directed testbench for text_page_render with a registered font ROM model.
module tb_text_page_render;

    localparam int NL = 2;
    localparam int MC = 16;
    localparam int GW = 8;
    localparam int GH = 16;
    localparam int CW = 10;
    localparam logic [15:0] BG = 16'h0841;

    logic              vga_clk;
    logic              sys_rst_n;
    logic [CW-1:0]     pix_x, pix_y;
    logic              pix_valid, frame_start;
    logic [NL*MC*5-1:0] line_text;
    logic [NL*5-1:0]   line_len;
    logic [NL*CW-1:0]  line_x, line_y;
    logic [NL*2-1:0]   line_scale;
    logic [NL*16-1:0]  line_fg;
    logic [NL-1:0]     line_blink;
    logic [15:0]       bg_color;
    logic [8:0]        font_addr;
    logic [GW-1:0]     font_data;
    logic [15:0]       pix_data;
    logic              pix_data_valid;

    int n_vec = 0;
    int n_bad = 0;

    text_page_render #(
        .N_LINES(NL), .MAX_CHARS(MC), .GLYPH_W(GW), .GLYPH_H(GH),
        .BLINK_FRAMES(2), .COORD_W(CW)
    ) dut (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y),
        .pix_valid(pix_valid), .frame_start(frame_start), .line_text(line_text),
        .line_len(line_len), .line_x(line_x), .line_y(line_y), .line_scale(line_scale),
        .line_fg(line_fg), .line_blink(line_blink), .bg_color(bg_color),
        .font_addr(font_addr), .font_data(font_data), .pix_data(pix_data),
        .pix_data_valid(pix_data_valid)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Font ROM: code 1 ('B') rows are 8'hF0, every other code/row is 8'hFF.
    always @(posedge vga_clk) begin
        font_data <= (font_addr[8:4] == 5'd1) ? 8'hF0 : 8'hFF;
    end

    task automatic set_line(input int i, input string s, input int len, input int x,
                            input int y, input int sc, input logic [15:0] fg, input logic bl);
        logic [4:0] c;
        for (int k = 0; k < MC; k++) begin
            if (k < s.len()) c = (s[k] == " ") ? 5'd26 : 5'(s[k] - 8'h41);
            else             c = 5'd26;
            line_text[(i*MC+k)*5 +: 5] = c;
        end
        line_len[i*5 +: 5]     = 5'(len);
        line_x[i*CW +: CW]     = 10'(x);
        line_y[i*CW +: CW]     = 10'(y);
        line_scale[i*2 +: 2]   = 2'(sc);
        line_fg[i*16 +: 16]    = fg;
        line_blink[i]          = bl;
    endtask

    // Drive one pixel for one cycle, then idle; capture output 3 edges later.
    task automatic run_pix(input int x, input int y, input logic v, input logic fs,
                           output logic [15:0] d, output logic dv, output logic dv_early);
        @(negedge vga_clk);
        pix_x = 10'(x); pix_y = 10'(y); pix_valid = v; frame_start = fs;
        @(negedge vga_clk);
        pix_valid = 1'b0; frame_start = 1'b0; pix_x = 10'd0; pix_y = 10'd0;
        @(negedge vga_clk);
        dv_early = pix_data_valid;
        @(negedge vga_clk);
        d = pix_data; dv = pix_data_valid;
    endtask

    task automatic pulse_frame();
        @(negedge vga_clk); frame_start = 1'b1;
        @(negedge vga_clk); frame_start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if (pix_data !== 16'h0000 || pix_data_valid !== 1'b0 || font_addr !== 9'd0) begin
            $display("FAIL reset_state: pix_data=%h valid=%b font_addr=%h expected 0000/0/000",
                     pix_data, pix_data_valid, font_addr);
            n_bad++;
        end
        repeat (3) @(negedge vga_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_snake();
        int xs[7]  = '{160, 159, 319, 320, 160, 160, 200};
        int ys[7]  = '{208, 208, 208, 208, 271, 272, 207};
        logic [15:0] ex[7] = '{16'h5746, BG, 16'h5746, BG, 16'h5746, BG, BG};
        logic [15:0] d; logic dv, dve;
        set_line(0, "SNAKE", 5, 160, 208, 2, 16'h5746, 1'b0);
        set_line(1, "", 0, 160, 208, 0, 16'hFFFF, 1'b0);
        // First vector by hand to check the font address and exact latency.
        @(negedge vga_clk);
        pix_x = 10'd160; pix_y = 10'd208; pix_valid = 1'b1;
        @(negedge vga_clk);
        pix_valid = 1'b0;
        n_vec++;
        if (font_addr !== 9'h120) begin
            $display("FAIL snake_font_addr: got %h expected 120", font_addr); n_bad++;
        end
        @(negedge vga_clk);
        n_vec++;
        if (pix_data_valid !== 1'b0) begin
            $display("FAIL snake_latency_early: valid=%b expected 0 after 2 cycles", pix_data_valid); n_bad++;
        end
        @(negedge vga_clk);
        n_vec++;
        if (pix_data !== 16'h5746 || pix_data_valid !== 1'b1) begin
            $display("FAIL snake_latency: pix_data=%h valid=%b expected 5746/1", pix_data, pix_data_valid); n_bad++;
        end
        for (int i = 0; i < 7; i++) begin
            run_pix(xs[i], ys[i], 1'b1, 1'b0, d, dv, dve);
            n_vec++;
            if (d !== ex[i] || dv !== 1'b1) begin
                $display("FAIL snake_pix%0d (%0d,%0d): got %h/%b expected %h/1", i, xs[i], ys[i], d, dv, ex[i]);
                n_bad++;
            end
        end
    endtask

    task automatic test_glyph_bits();
        int xs[5]  = '{8, 12, 16, 24, 32};
        logic [15:0] ex[5] = '{16'hFFFF, BG, BG, 16'hFFFF, BG};
        logic [15:0] d; logic dv, dve;
        set_line(0, "AB C", 4, 0, 0, 0, 16'hFFFF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            run_pix(xs[i], 0, 1'b1, 1'b0, d, dv, dve);
            n_vec++;
            if (d !== ex[i]) begin
                $display("FAIL glyph_bits x=%0d: got %h expected %h", xs[i], d, ex[i]); n_bad++;
            end
        end
        // Scale 1: 'B' pattern F0 is four source pixels wide, eight screen pixels.
        set_line(0, "B", 1, 0, 0, 1, 16'hFFFF, 1'b0);
        run_pix(7, 0, 1'b1, 1'b0, d, dv, dve);
        n_vec++;
        if (d !== 16'hFFFF) begin $display("FAIL scale1_on: got %h expected ffff", d); n_bad++; end
        run_pix(8, 0, 1'b1, 1'b0, d, dv, dve);
        n_vec++;
        if (d !== BG) begin $display("FAIL scale1_off: got %h expected %h", d, BG); n_bad++; end
    endtask

    task automatic test_overlap();
        logic [15:0] d; logic dv, dve;
        set_line(0, "A", 1, 100, 100, 0, 16'hF800, 1'b0);
        set_line(1, "AA", 2, 100, 100, 0, 16'h001F, 1'b0);
        run_pix(100, 100, 1'b1, 1'b0, d, dv, dve);
        n_vec++;
        if (d !== 16'hF800) begin $display("FAIL overlap_priority: got %h expected f800", d); n_bad++; end
        run_pix(108, 100, 1'b1, 1'b0, d, dv, dve);
        n_vec++;
        if (d !== 16'h001F) begin $display("FAIL overlap_line1_only: got %h expected 001f", d); n_bad++; end
    endtask

    task automatic test_edges();
        logic [15:0] d; logic dv, dve;
        set_line(1, "", 0, 0, 0, 0, 16'h001F, 1'b0);
        set_line(0, "ABCDEFGH", 8, 600, 0, 0, 16'hF800, 1'b0);
        run_pix(5, 0, 1'b1, 1'b0, d, dv, dve);
        n_vec++;
        if (d !== BG) begin $display("FAIL edge_left_600: got %h expected %h", d, BG); n_bad++; end
        run_pix(639, 0, 1'b1, 1'b0, d, dv, dve);
        n_vec++;
        if (d !== 16'hF800) begin $display("FAIL edge_clip_639: got %h expected f800", d); n_bad++; end
        set_line(0, "ABCDEFGH", 8, 1000, 0, 0, 16'hF800, 1'b0);
        run_pix(5, 0, 1'b1, 1'b0, d, dv, dve);
        n_vec++;
        if (d !== BG) begin $display("FAIL edge_underflow: got %h expected %h", d, BG); n_bad++; end
        set_line(0, "AAAAAAAAAAAAAAAA", 31, 0, 0, 0, 16'hF800, 1'b0);
        run_pix(127, 0, 1'b1, 1'b0, d, dv, dve);
        n_vec++;
        if (d !== 16'hF800) begin $display("FAIL len_clamp_last: got %h expected f800", d); n_bad++; end
        run_pix(128, 0, 1'b1, 1'b0, d, dv, dve);
        n_vec++;
        if (d !== BG) begin $display("FAIL len_clamp_past: got %h expected %h", d, BG); n_bad++; end
        set_line(0, "AAAA", 0, 0, 0, 0, 16'hF800, 1'b0);
        run_pix(0, 0, 1'b1, 1'b0, d, dv, dve);
        n_vec++;
        if (d !== BG) begin $display("FAIL len_zero: got %h expected %h", d, BG); n_bad++; end
        run_pix(0, 0, 1'b0, 1'b0, d, dv, dve);
        n_vec++;
        if (d !== 16'h0000 || dv !== 1'b0) begin
            $display("FAIL invalid_pixel: got %h/%b expected 0000/0", d, dv); n_bad++;
        end
    endtask

    task automatic test_blink();
        logic [15:0] d; logic dv, dve;
        set_line(0, "A", 1, 0, 0, 0, 16'hF800, 1'b0);
        set_line(1, "A", 1, 0, 100, 0, 16'h001F, 1'b1);
        run_pix(0, 100, 1'b1, 1'b0, d, dv, dve);
        n_vec++;
        if (d !== 16'h001F) begin $display("FAIL blink_initial: got %h expected 001f", d); n_bad++; end
        pulse_frame();
        run_pix(0, 100, 1'b1, 1'b0, d, dv, dve);
        n_vec++;
        if (d !== 16'h001F) begin $display("FAIL blink_after1: got %h expected 001f", d); n_bad++; end
        pulse_frame();
        run_pix(0, 100, 1'b1, 1'b0, d, dv, dve);
        n_vec++;
        if (d !== BG) begin $display("FAIL blink_hidden: got %h expected %h", d, BG); n_bad++; end
        run_pix(0, 0, 1'b1, 1'b0, d, dv, dve);
        n_vec++;
        if (d !== 16'hF800) begin $display("FAIL blink_line0_steady: got %h expected f800", d); n_bad++; end
        pulse_frame();
        // Pixel coincident with the wrapping frame_start still sees the hidden phase.
        run_pix(0, 100, 1'b1, 1'b1, d, dv, dve);
        n_vec++;
        if (d !== BG) begin $display("FAIL blink_same_cycle: got %h expected %h", d, BG); n_bad++; end
        run_pix(0, 100, 1'b1, 1'b0, d, dv, dve);
        n_vec++;
        if (d !== 16'h001F) begin $display("FAIL blink_restored: got %h expected 001f", d); n_bad++; end
    endtask

    task automatic test_mid_reset();
        logic [15:0] d; logic dv, dve;
        pulse_frame();
        pulse_frame();
        @(negedge vga_clk);
        pix_x = 10'd0; pix_y = 10'd0; pix_valid = 1'b1;
        repeat (3) @(negedge vga_clk);
        n_vec++;
        if (pix_data !== 16'hF800) begin $display("FAIL rst_prerun: got %h expected f800", pix_data); n_bad++; end
        sys_rst_n = 1'b0;
        #1;
        n_vec++;
        if (pix_data !== 16'h0000 || pix_data_valid !== 1'b0) begin
            $display("FAIL rst_async: got %h/%b expected 0000/0", pix_data, pix_data_valid); n_bad++;
        end
        pix_valid = 1'b0;
        @(negedge vga_clk);
        sys_rst_n = 1'b1;
        run_pix(0, 100, 1'b1, 1'b0, d, dv, dve);
        n_vec++;
        if (dve !== 1'b0 || d !== 16'h001F || dv !== 1'b1) begin
            $display("FAIL rst_resume: got %h/%b early=%b expected 001f/1 early=0", d, dv, dve); n_bad++;
        end
    endtask

    initial begin
        sys_rst_n = 1'b0; pix_x = '0; pix_y = '0; pix_valid = 1'b0; frame_start = 1'b0;
        line_text = '0; line_len = '0; line_x = '0; line_y = '0; line_scale = '0;
        line_fg = '0; line_blink = '0; bg_color = BG;
        test_reset();
        test_snake();
        test_glyph_bits();
        test_overlap();
        test_edges();
        test_blink();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
